// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM request arbiter.
package sdram_arb_pkg;

    // Command register widths; the arbiter's ADDR_W_p/DATA_W_p must not exceed these.
    localparam int CMD_ADDR_W = 24;
    localparam int CMD_DATA_W = 16;

    // IDLE: choose refresh or request | ISSUE: offer cmd | WAIT_RD: await read data | REF: offer refresh
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        REF     = 2'd3
    } state_e;

    typedef struct packed {
        logic                  we;
        logic                  is_ref;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] wdata;
    } cmd_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sdram_req_arbiter_rr.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps around.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any && req[(int'(ptr) + k) % N]) begin
                any                          = 1'b1;
                grant[(int'(ptr) + k) % N]   = 1'b1;
                idx                          = IDX_W'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/sdram_req_arbiter.sv
// Shares one SDRAM command port between NUM_REQ_p requesters and inserts periodic refresh.
// Define SDRAM_ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
module sdram_req_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_REQ_p      = 4,
    parameter int ADDR_W_p       = 24,
    parameter int DATA_W_p       = 16,
    parameter int REF_INTERVAL_p = 1037
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ_p-1:0]          req_valid_i,
    input  logic [NUM_REQ_p-1:0]          req_we_i,
    input  logic [NUM_REQ_p*ADDR_W_p-1:0] req_addr_i,
    input  logic [NUM_REQ_p*DATA_W_p-1:0] req_wdata_i,
    output logic [NUM_REQ_p-1:0]          req_ready_o,
    output logic [NUM_REQ_p-1:0]          rsp_valid_o,
    output logic [DATA_W_p-1:0]           rsp_rdata_o,
    output logic                          mem_valid_o,
    input  logic                          mem_ready_i,
    output logic                          mem_we_o,
    output logic                          mem_ref_o,
    output logic [ADDR_W_p-1:0]           mem_addr_o,
    output logic [DATA_W_p-1:0]           mem_wdata_o,
    input  logic                          mem_rvalid_i,
    input  logic [DATA_W_p-1:0]           mem_rdata_i
);

    localparam int IDX_W = idx_w(NUM_REQ_p);
    localparam int CNT_W = $clog2(REF_INTERVAL_p + 1);

    state_e               state_q, state_d;
    cmd_t                 cmd_q;
    logic [IDX_W-1:0]     owner_q;
    logic                 ref_pend_q;
    logic [CNT_W-1:0]     ref_cnt_q;
    logic                 ref_tick;

    logic [NUM_REQ_p-1:0] grant;
    logic [IDX_W-1:0]     grant_idx;
    logic                 grant_any;
    logic                 grant_fire;

    logic                 sel_we;
    logic [ADDR_W_p-1:0]  sel_addr;
    logic [DATA_W_p-1:0]  sel_wdata;

`ifdef SDRAM_ARB_FIXED_PRIO_EN
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int i = 0; i < NUM_REQ_p; i++) begin
            if (!grant_any && req_valid_i[i]) begin
                grant_any = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = IDX_W'(i);
            end
        end
    end
`else
    logic [IDX_W-1:0] rr_q;

    rr_arbiter #(
        .N     (NUM_REQ_p),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req   (req_valid_i),
        .ptr   (rr_q),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= '0;
        end else if (grant_fire) begin
            rr_q <= (grant_idx == IDX_W'(NUM_REQ_p - 1)) ? '0 : grant_idx + 1'b1;
        end
    end
`endif

    // Ready is combinational, so it is held low while reset is asserted.
    assign grant_fire  = rst_ni && (state_q == IDLE) && !ref_pend_q && grant_any;
    assign req_ready_o = grant_fire ? grant : '0;

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ_p; i++) begin
            if (grant[i]) begin
                sel_we    = req_we_i[i];
                sel_addr  = req_addr_i[i*ADDR_W_p +: ADDR_W_p];
                sel_wdata = req_wdata_i[i*DATA_W_p +: DATA_W_p];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (ref_pend_q)     state_d = REF;
                else if (grant_any) state_d = ISSUE;
            end
            ISSUE: begin
                if (mem_ready_i)    state_d = cmd_q.we ? IDLE : WAIT_RD;
            end
            WAIT_RD: begin
                if (mem_rvalid_i)   state_d = IDLE;
            end
            REF: begin
                if (mem_ready_i)    state_d = IDLE;
            end
            default:                state_d = IDLE;
        endcase
    end

    // The counter reloads on the step that would reach zero, giving one tick every REF_INTERVAL_p clocks.
    assign ref_tick = (ref_cnt_q == CNT_W'(1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            owner_q     <= '0;
            ref_pend_q  <= 1'b0;
            ref_cnt_q   <= CNT_W'(REF_INTERVAL_p);
            rsp_valid_o <= '0;
            rsp_rdata_o <= '0;
        end else begin
            state_q   <= state_d;
            ref_cnt_q <= ref_tick ? CNT_W'(REF_INTERVAL_p) : ref_cnt_q - 1'b1;

            if (ref_tick) begin
                ref_pend_q <= 1'b1;
            end else if ((state_q == REF) && mem_ready_i) begin
                ref_pend_q <= 1'b0;
            end

            if (grant_fire) begin
                cmd_q.we     <= sel_we;
                cmd_q.is_ref <= 1'b0;
                cmd_q.addr   <= CMD_ADDR_W'(sel_addr);
                cmd_q.wdata  <= CMD_DATA_W'(sel_wdata);
                owner_q      <= grant_idx;
            end else if ((state_q == IDLE) && ref_pend_q) begin
                cmd_q        <= '0;
                cmd_q.is_ref <= 1'b1;
            end

            rsp_valid_o <= '0;
            if ((state_q == WAIT_RD) && mem_rvalid_i) begin
                rsp_valid_o[owner_q] <= 1'b1;
                rsp_rdata_o          <= mem_rdata_i;
            end
        end
    end

    assign mem_valid_o = (state_q == ISSUE) || (state_q == REF);
    assign mem_ref_o   = mem_valid_o && cmd_q.is_ref;
    assign mem_we_o    = mem_valid_o && cmd_q.we;
    assign mem_addr_o  = cmd_q.addr[ADDR_W_p-1:0];
    assign mem_wdata_o = cmd_q.wdata[DATA_W_p-1:0];

endmodule
